// File: rtl/poly_coeff_collector_pkg.sv
// Shared Kyber constants and collector state encoding.
package poly_coeff_collector_pkg;

    localparam int KYBER_K  = 2;
    localparam int KYBER_N  = 256;
    localparam int KYBER_Q  = 3329;
    localparam int COEFF_SZ = 16;
    localparam int LANES    = 8;
    localparam int WORD_SZ  = LANES * COEFF_SZ;
    localparam int WORDS    = KYBER_K * KYBER_N / LANES;
    localparam int ADDR_W   = $clog2(WORDS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

endpackage

// File: rtl/poly_coeff_collector_csubq.sv
// Eight-lane conditional subtract of q on 12-bit coefficients, plus an any-lane >= q flag.
module poly_coeff_collector__csubq
    import poly_coeff_collector_pkg::*;
(
    input  logic [WORD_SZ-1:0] word_in,
    output logic [WORD_SZ-1:0] word_out,
    output logic               any_ge_q
);

    localparam logic [11:0] Q12 = 12'(KYBER_Q);

    logic [LANES-1:0]   ge_vec;
    logic [LANES*4-1:0] unused_hi;

    // A single subtract suffices: 4095 - 3329 = 766 < q.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [11:0] c;
        assign c         = word_in[i*COEFF_SZ +: 12];
        assign ge_vec[i] = (c >= Q12);
        assign word_out[i*COEFF_SZ +: COEFF_SZ] = {4'b0000, ge_vec[i] ? (c - Q12) : c};
        assign unused_hi[i*4 +: 4] = word_in[i*COEFF_SZ+12 +: 4];
    end

    assign any_ge_q = |ge_vec;

endmodule

// File: rtl/poly_coeff_collector.sv
// Collects unpacked coefficient words, reduces them mod q and writes them to the poly-vector buffer.
module poly_coeff_collector
    import poly_coeff_collector_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               in_valid,
    input  logic [WORD_SZ-1:0] in_data,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [WORD_SZ-1:0] wr_data,
    output logic               busy,
    output logic               done,
    output logic               range_err,
    output logic               overflow
);

    // state   | meaning
    // IDLE    | waiting for start; in_valid ignored
    // COLLECT | accepting words, one per in_valid cycle
    // FLUSH   | one cycle: last write + done; in_valid here is an overflow

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    state_t             state;
    logic [ADDR_W-1:0]  count;
    logic [WORD_SZ-1:0] reduced;
    logic               any_ge_q;

    poly_coeff_collector__csubq u_csubq (
        .word_in  (in_data),
        .word_out (reduced),
        .any_ge_q (any_ge_q)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            count     <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            range_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_COLLECT;
                        busy      <= 1'b1;
                        count     <= '0;
                        range_err <= 1'b0;
                        overflow  <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    if (in_valid) begin
                        wr_en     <= 1'b1;
                        wr_addr   <= count;
                        wr_data   <= reduced;
                        range_err <= range_err | any_ge_q;
                        // Counter holds at the last address so it never wraps.
                        if (count == LAST_ADDR) begin
                            state <= ST_FLUSH;
                            done  <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    if (in_valid) begin
                        overflow <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poly_coeff_collector.sv
// Randomized and directed bench for poly_coeff_collector against a behavioural run model.
module tb_poly_coeff_collector;

    localparam int K       = 2;
    localparam int N       = 256;
    localparam int Q       = 3329;
    localparam int NLANES  = 8;
    localparam int NWORDS  = K * N / NLANES;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         start = 1'b0;
    logic         in_valid = 1'b0;
    logic [127:0] in_data = '0;
    logic         wr_en;
    logic [5:0]   wr_addr;
    logic [127:0] wr_data;
    logic         busy;
    logic         done;
    logic         range_err;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    // Reference model: run phase expressed as "collecting", "in flush cycle" and words accepted.
    bit   m_collecting = 0;
    bit   m_flush      = 0;
    int   m_accepted   = 0;
    bit   m_rerr       = 0;
    bit   m_ovf        = 0;
    bit   e_wr_en      = 0;
    bit   e_done       = 0;
    int   e_addr       = 0;
    logic [127:0] e_data = '0;
    int   writes_seen  = 0;
    int   dones_seen   = 0;

    poly_coeff_collector dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .range_err (range_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] ref_reduce(input logic [127:0] d, output bit any_ge);
        logic [127:0] r;
        int c;
        r = '0;
        any_ge = 0;
        for (int i = 0; i < NLANES; i++) begin
            c = int'(d[i*16 +: 12]);
            if (c >= Q) any_ge = 1;
            r[i*16 +: 16] = 16'(c % Q);
        end
        return r;
    endfunction

    function automatic logic [127:0] rand_word();
        logic [127:0] w;
        for (int i = 0; i < 4; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic check_outputs(input string ctx);
        chk({ctx, ".wr_en"}, 128'(wr_en), 128'(e_wr_en));
        chk({ctx, ".done"}, 128'(done), 128'(e_done));
        chk({ctx, ".busy"}, 128'(busy), 128'(m_collecting | m_flush));
        chk({ctx, ".range_err"}, 128'(range_err), 128'(m_rerr));
        chk({ctx, ".overflow"}, 128'(overflow), 128'(m_ovf));
        if (e_wr_en) begin
            chk({ctx, ".wr_addr"}, 128'(wr_addr), 128'(e_addr));
            chk({ctx, ".wr_data"}, wr_data, e_data);
        end
        if (wr_en) writes_seen++;
        if (done)  dones_seen++;
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic step(input string ctx, input bit s, input bit v, input logic [127:0] d);
        bit ge;
        logic [127:0] r;
        start    = s;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
        e_wr_en = 0;
        e_done  = 0;
        if (m_flush) begin
            m_flush = 0;
            if (v) m_ovf = 1;
        end else if (m_collecting) begin
            if (v) begin
                r       = ref_reduce(d, ge);
                e_wr_en = 1;
                e_addr  = m_accepted;
                e_data  = r;
                if (ge) m_rerr = 1;
                m_accepted++;
                if (m_accepted == NWORDS) begin
                    m_collecting = 0;
                    m_flush      = 1;
                    e_done       = 1;
                end
            end
        end else if (s) begin
            m_collecting = 1;
            m_accepted   = 0;
            m_rerr       = 0;
            m_ovf        = 0;
        end
        check_outputs(ctx);
    endtask

    task automatic model_reset();
        m_collecting = 0;
        m_flush      = 0;
        m_accepted   = 0;
        m_rerr       = 0;
        m_ovf        = 0;
        e_wr_en      = 0;
        e_done       = 0;
    endtask

    task automatic check_all_zero(input string ctx);
        chk({ctx, ".wr_en"}, 128'(wr_en), 128'(0));
        chk({ctx, ".wr_addr"}, 128'(wr_addr), 128'(0));
        chk({ctx, ".wr_data"}, wr_data, 128'(0));
        chk({ctx, ".busy"}, 128'(busy), 128'(0));
        chk({ctx, ".done"}, 128'(done), 128'(0));
        chk({ctx, ".range_err"}, 128'(range_err), 128'(0));
        chk({ctx, ".overflow"}, 128'(overflow), 128'(0));
    endtask

    task automatic full_random_run(input string ctx);
        step({ctx, "_start"}, 1, 0, '0);
        for (int w = 0; w < NWORDS; w++) step(ctx, 0, 1, rand_word());
        step({ctx, "_post"}, 0, 0, '0);
    endtask

    initial begin
        logic [127:0] ones_word;
        logic [127:0] nom_word;
        logic [127:0] red_in;
        logic [127:0] red_exp;
        int           red_in_l [NLANES];
        int           red_exp_l[NLANES];
        int           w;

        red_in_l  = '{0, 3328, 3329, 3330, 4095, 1, 16'h1D01, 16'hF000};
        red_exp_l = '{0, 3328, 0, 1, 766, 1, 0, 0};
        for (int i = 0; i < NLANES; i++) begin
            red_in[i*16 +: 16]  = 16'(red_in_l[i]);
            red_exp[i*16 +: 16] = 16'(red_exp_l[i]);
        end

        // Reset state
        resetn = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        resetn = 1'b1;

        // Idle: in_valid ignored without start
        for (int i = 0; i < NLANES; i++) ones_word[i*16 +: 16] = 16'h0FFF;
        for (int i = 0; i < 5; i++) step("idle", 0, 1, ones_word);

        // Nominal back-to-back run, lane i of word w = 8w+i
        writes_seen = 0;
        dones_seen  = 0;
        step("nom_start", 1, 0, '0);
        for (int wi = 0; wi < NWORDS; wi++) begin
            for (int i = 0; i < NLANES; i++) nom_word[i*16 +: 16] = 16'(8*wi + i);
            step("nom", 0, 1, nom_word);
            chk("nom.passthru", wr_data, nom_word);
        end
        step("nom_post", 0, 0, '0);
        chk("nom.write_count", 128'(writes_seen), 128'(NWORDS));
        chk("nom.done_count", 128'(dones_seen), 128'(1));

        // Reduction boundary word, then random fill
        step("red_start", 1, 0, '0);
        step("red", 0, 1, red_in);
        chk("red.literal", wr_data, red_exp);
        chk("red.range_err", 128'(range_err), 128'(1));
        for (int wi = 1; wi < NWORDS; wi++) step("red_rand", 0, 1, rand_word());
        step("red_post", 0, 0, '0);

        // Gapped input: valid every 3rd cycle
        step("gap_start", 1, 0, '0);
        w = 0;
        for (int cyc = 0; w < NWORDS && cyc < 400; cyc++) begin
            if (cyc % 3 == 2) begin
                step("gap", 0, 1, rand_word());
                w++;
            end else begin
                step("gap_idle", 0, 0, rand_word());
            end
        end
        chk("gap.words_sent", 128'(w), 128'(NWORDS));
        step("gap_post", 0, 0, '0);

        // Start misuse mid-run, then in_valid + start during the FLUSH cycle
        writes_seen = 0;
        step("mis_start", 1, 0, '0);
        for (int wi = 0; wi < NWORDS; wi++) step("mis", (wi == 10), 1, rand_word());
        step("mis_flush", 1, 1, rand_word());
        chk("mis.overflow", 128'(overflow), 128'(1));
        chk("mis.busy_after_flush", 128'(busy), 128'(0));
        step("mis_idle", 0, 1, rand_word());
        chk("mis.write_count", 128'(writes_seen), 128'(NWORDS));
        step("mis_restart", 1, 0, '0);
        chk("mis.restart_ovf", 128'(overflow), 128'(0));
        chk("mis.restart_rerr", 128'(range_err), 128'(0));
        for (int wi = 0; wi < NWORDS; wi++) step("mis_run2", 0, 1, rand_word());
        step("mis_post", 0, 0, '0);

        // Reset mid-run
        step("rst_start", 1, 0, '0);
        for (int wi = 0; wi < 20; wi++) step("rst_pre", 0, 1, rand_word());
        start    = 1'b0;
        in_valid = 1'b1;
        resetn   = 1'b0;
        #2;
        model_reset();
        check_all_zero("rst_mid");
        @(posedge clk);
        #1;
        check_all_zero("rst_held");
        @(negedge clk);
        resetn = 1'b1;
        step("rst_idle", 0, 1, rand_word());
        full_random_run("rst_run");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
